// File: rtl/button_event.sv
`default_nettype none
// ============================================================================
// Module      : button_event
// Description : Classifies a debounced switch level into single-cycle press,
//               release, long-press and double-click pulses, plus a held
//               level and a toggle level that flips on each resolved single
//               click. All outputs are registered.
// Revision    : 1.0 - initial release
// ============================================================================
module button_event #(
    parameter int CLOCK_RATE_HZ       = 50_000_000,
    parameter int LONG_PRESS_CYCLES   = CLOCK_RATE_HZ,
    parameter int DOUBLE_CLICK_CYCLES = CLOCK_RATE_HZ / 4,
    parameter int CNT_W               = 26,
    parameter int ACTIVE_LOW          = 1
) (
    input  logic clk,
    input  logic rst_n,
    input  logic i_switch,
    output logic o_press,
    output logic o_release,
    output logic o_long,
    output logic o_double,
    output logic o_held,
    output logic o_toggle
);

    localparam logic [CNT_W-1:0] C_LONG_LAST = CNT_W'(LONG_PRESS_CYCLES - 1);
    localparam logic [CNT_W-1:0] C_DBL_LAST  = CNT_W'(DOUBLE_CLICK_CYCLES - 1);
    localparam logic [CNT_W-1:0] C_TMR_MAX   = {CNT_W{1'b1}};

    typedef enum logic [2:0] {
        S_IDLE      = 3'd0,
        S_PRESSED   = 3'd1,
        S_LONG_HELD = 3'd2,
        S_GAP       = 3'd3,
        S_SECOND    = 3'd4
    } state_t;

    state_t           r_state;
    state_t           w_state_nxt;
    logic [CNT_W-1:0] r_timer;
    logic [CNT_W-1:0] w_timer_nxt;
    logic [CNT_W-1:0] w_timer_inc;
    logic             r_prev;
    logic             r_press;
    logic             r_release;
    logic             r_long;
    logic             r_double;
    logic             r_held;
    logic             r_toggle;

    logic w_p;
    logic w_press_edge;
    logic w_release_edge;
    logic w_press;
    logic w_release;
    logic w_long;
    logic w_double;
    logic w_flip;
    logic w_held_nxt;

    // Normalise the switch polarity so that w_p is 1 while pressed.
    assign w_p            = (ACTIVE_LOW != 0) ? ~i_switch : i_switch;
    assign w_press_edge   = w_p & ~r_prev;
    assign w_release_edge = ~w_p & r_prev;
    // Timer saturates at all-ones instead of wrapping.
    assign w_timer_inc    = (r_timer == C_TMR_MAX) ? r_timer : r_timer + CNT_W'(1);

    // State register; reset abandons any event in flight.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    // Next-state, timer and event decode.
    always_comb begin
        w_state_nxt = r_state;
        w_timer_nxt = r_timer;
        w_press     = 1'b0;
        w_release   = 1'b0;
        w_long      = 1'b0;
        w_double    = 1'b0;
        w_flip      = 1'b0;
        case (r_state)
            S_IDLE: begin
                if (w_press_edge) begin
                    w_press     = 1'b1;
                    w_timer_nxt = '0;
                    w_state_nxt = S_PRESSED;
                end
            end
            S_PRESSED: begin
                if (w_release_edge) begin
                    w_release   = 1'b1;
                    w_timer_nxt = '0;
                    w_state_nxt = S_GAP;
                end else if (r_timer == C_LONG_LAST) begin
                    w_long      = 1'b1;
                    w_state_nxt = S_LONG_HELD;
                end else begin
                    w_timer_nxt = w_timer_inc;
                end
            end
            S_LONG_HELD: begin
                if (w_release_edge) begin
                    w_release   = 1'b1;
                    w_state_nxt = S_IDLE;
                end
            end
            S_GAP: begin
                // A press in the timeout cycle still counts as a double click.
                if (w_press_edge) begin
                    w_press     = 1'b1;
                    w_double    = 1'b1;
                    w_state_nxt = S_SECOND;
                end else if (r_timer == C_DBL_LAST) begin
                    w_flip      = 1'b1;
                    w_state_nxt = S_IDLE;
                end else begin
                    w_timer_nxt = w_timer_inc;
                end
            end
            S_SECOND: begin
                if (w_release_edge) begin
                    w_release   = 1'b1;
                    w_state_nxt = S_IDLE;
                end
            end
            default: begin
                w_state_nxt = S_IDLE;
                w_timer_nxt = '0;
            end
        endcase
        w_held_nxt = (w_state_nxt == S_PRESSED) || (w_state_nxt == S_LONG_HELD) ||
                     (w_state_nxt == S_SECOND);
    end

    // Timer, previous level and registered outputs.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_timer   <= '0;
            r_prev    <= 1'b0;
            r_press   <= 1'b0;
            r_release <= 1'b0;
            r_long    <= 1'b0;
            r_double  <= 1'b0;
            r_held    <= 1'b0;
            r_toggle  <= 1'b0;
        end else begin
            r_timer   <= w_timer_nxt;
            r_prev    <= w_p;
            r_press   <= w_press;
            r_release <= w_release;
            r_long    <= w_long;
            r_double  <= w_double;
            r_held    <= w_held_nxt;
            r_toggle  <= r_toggle ^ w_flip;
        end
    end

    assign o_press   = r_press;
    assign o_release = r_release;
    assign o_long    = r_long;
    assign o_double  = r_double;
    assign o_held    = r_held;
    assign o_toggle  = r_toggle;

endmodule
`default_nettype wire

// File: doc/button_event.md
Name: button_event

Overview:
- Sits directly downstream of the switch debouncer.
- Consumes the debounced, active-low switch level and classifies it into single-cycle event pulses: press, release, long-press and double-click.
- Also provides a held level and a toggle output that flips on each resolved single click, suitable for driving an LED.
- All outputs are registered and synchronous to the same clock as the debouncer.

Parameters:
- CLOCK_RATE_HZ, 50_000_000, system clock frequency in Hz.
- LONG_PRESS_CYCLES, CLOCK_RATE_HZ (1 s), continuous pressed cycles that qualify as a long press; legal range 2..2^CNT_W-1.
- DOUBLE_CLICK_CYCLES, CLOCK_RATE_HZ/4 (250 ms), maximum released gap after a first click in which a second press counts as a double click; legal range 2..2^CNT_W-1.
- CNT_W, 26, timer width in bits; must hold max(LONG_PRESS_CYCLES, DOUBLE_CLICK_CYCLES).
- ACTIVE_LOW, 1, 1 = i_switch low means pressed; 0 = high means pressed.

Ports:
- clk, input, 1, system clock; all state updates on the rising edge.
- rst_n, input, 1, asynchronous active-low reset.
- i_switch, input, 1, debounced switch level, already synchronous to clk.
- o_press, output, 1, one-cycle pulse on each press.
- o_release, output, 1, one-cycle pulse on each release.
- o_long, output, 1, one-cycle pulse when a press reaches LONG_PRESS_CYCLES.
- o_double, output, 1, one-cycle pulse on the second press of a double click.
- o_held, output, 1, level; high while the button is pressed, as tracked by the FSM.
- o_toggle, output, 1, level; flips once per resolved single click.

Behaviour:
- Reset:
  - rst_n low immediately forces FSM=IDLE, timer=0 and all pulse outputs=0.
  - o_held=0 and o_toggle=0.
  - Internal previous-level register is set to "released".
  - Reset asserted mid-press or mid-gap abandons the event silently; no pulses are emitted.
  - After reset release, a switch that is already pressed produces o_press on its first sampled cycle, because the previous level is "released".
- Definitions:
  - p = pressed level of i_switch, per ACTIVE_LOW.
  - Press edge: p=1 while previous sample = 0.
  - Release edge: p=0 while previous sample = 1.
- Latency: every pulse is registered and appears the cycle after the clk edge that samples the causing condition. Every pulse is exactly 1 cycle wide.
- FSM states: IDLE, PRESSED, LONG_HELD, GAP, SECOND.
- IDLE:
  - Press edge: o_press=1, timer=0, go to PRESSED.
- PRESSED:
  - timer increments each cycle.
  - Release edge: o_release=1, timer=0, go to GAP.
  - Else, when timer == LONG_PRESS_CYCLES-1: o_long=1, go to LONG_HELD; timer holds.
- LONG_HELD:
  - Release edge: o_release=1, go to IDLE.
  - A long press never contributes to a click, toggle or double.
- GAP:
  - timer increments each cycle.
  - Press edge: o_press=1, o_double=1, go to SECOND.
  - Else, when timer == DOUBLE_CLICK_CYCLES-1: o_toggle flips, go to IDLE.
  - Press edge in the same cycle as timeout: the press wins, giving a double click with no toggle.
- SECOND:
  - Release edge: o_release=1, go to IDLE.
  - No long-press detection in this state; the timer is idle.
- o_held = 1 in PRESSED, LONG_HELD and SECOND; 0 otherwise.
- Arithmetic and width rules:
  - Timer is unsigned CNT_W bits and saturates; it never wraps.
  - Comparisons use equality against the parameter minus 1.
- Input handling: no metastability handling and no debounce inside this block; i_switch is trusted to be clean.

Test Plan (LONG_PRESS_CYCLES=20, DOUBLE_CLICK_CYCLES=10, ACTIVE_LOW=1):
- Reset: hold rst_n=0 with i_switch=0 → all outputs 0. Release rst_n → o_press=1 for exactly one cycle, o_held=1.
- Single click: press for 5 cycles, then release → o_press and o_release once each. o_toggle flips 0→1 exactly 10 cycles after release. o_double and o_long never assert.
- Long press: hold pressed for 30 cycles → o_long pulses once, 20 cycles after o_press; no further o_long. On release, o_release=1 and o_toggle stays unchanged.
- Double click: press 3 cycles, release 4 cycles, press 3 cycles, release → o_press x2, o_double x1 (same cycle as the second o_press), o_release x2, o_toggle unchanged.
- Gap boundary: second press lands exactly in the timeout cycle → o_double=1, no toggle. Second press one cycle later → toggle flips, then a fresh o_press with no o_double.
- Reset mid-event: assert rst_n=0 during GAP at timer=5 → no toggle. After reset release with i_switch=1, all outputs stay 0.
